// File: rtl/secded_err_logger_if.sv
// secded_err_logger_if
// Handshake bundle between the SEC/DED decoder, the logging stage and the
// downstream consumer.
//   in_valid/in_ready : decoder result handshake
//   in_data           : corrected 16-bit word
//   in_sec/in_ded     : single-corrected / double-detected flags
//   in_addr           : word address (ADDR_W bits)
//   out_valid/out_ready : registered-word handshake toward the consumer
//   out_data/out_err  : registered word and its {ded, sec} flags
// master = decoder/consumer side, slave = the logging stage.
interface secded_err_logger_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_data;
  logic              in_sec;
  logic              in_ded;
  logic [ADDR_W-1:0] in_addr;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic [1:0]        out_err;

  modport master (
    output in_valid, in_data, in_sec, in_ded, in_addr, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, in_sec, in_ded, in_addr, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/secded_err_logger.sv
// secded_err_logger
// Registered, flow-controlled output stage behind the combinational 16-bit
// SEC/DED decoder, with saturating error counters and first-DED capture.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : secded_err_logger_if.slave (input and output handshakes)
//   log_clr  : synchronous clear of counters and DED capture
//   sec_cnt  : saturating count of accepted SEC-only words
//   ded_cnt  : saturating count of accepted DED words
//   ded_seen : a DED has been accepted since reset/clear
//   ded_addr : address of the first DED accepted
// Build option: define SECDED_LOG_ADDR_EN to implement the ded_addr capture
// register; otherwise ded_addr is tied to zero and in_addr is ignored.
module secded_err_logger #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  secded_err_logger_if.slave   bus,
  input  logic                 log_clr,
  output logic [CNT_W-1:0]     sec_cnt,
  output logic [CNT_W-1:0]     ded_cnt,
  output logic                 ded_seen,
  output logic [ADDR_W-1:0]    ded_addr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              out_valid_reg;
  logic [15:0]       out_data_reg;
  logic [1:0]        out_err_reg;
  logic [CNT_W-1:0]  sec_cnt_reg;
  logic [CNT_W-1:0]  ded_cnt_reg;
  logic              ded_seen_reg;
  logic              accept;

  // Ready passes straight through from the consumer so a full register can
  // be refilled in the same cycle it drains.
  assign bus.in_ready  = ~out_valid_reg | bus.out_ready;
  assign accept        = bus.in_valid & bus.in_ready;

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_err   = out_err_reg;
  assign sec_cnt       = sec_cnt_reg;
  assign ded_cnt       = ded_cnt_reg;
  assign ded_seen      = ded_seen_reg;

  // Output register: data/err only change on accept, so they stay stable
  // while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_err_reg   <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= bus.in_data;
      // A word flagged both ways is treated as DED only.
      out_err_reg   <= {bus.in_ded, bus.in_sec & ~bus.in_ded};
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Error counters; a clear in the same cycle as a counted accept wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt_reg  <= '0;
      ded_cnt_reg  <= '0;
      ded_seen_reg <= 1'b0;
    end else if (log_clr) begin
      sec_cnt_reg  <= '0;
      ded_cnt_reg  <= '0;
      ded_seen_reg <= 1'b0;
    end else if (accept) begin
      if (bus.in_ded) begin
        if (ded_cnt_reg != CNT_MAX) ded_cnt_reg <= ded_cnt_reg + 1'b1;
        ded_seen_reg <= 1'b1;
      end else if (bus.in_sec) begin
        if (sec_cnt_reg != CNT_MAX) sec_cnt_reg <= sec_cnt_reg + 1'b1;
      end
    end
  end

`ifdef SECDED_LOG_ADDR_EN
  logic [ADDR_W-1:0] ded_addr_reg;

  // Only the first DED since reset/clear is captured; ded_seen gates later ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ded_addr_reg <= '0;
    end else if (log_clr) begin
      ded_addr_reg <= '0;
    end else if (accept && bus.in_ded && !ded_seen_reg) begin
      ded_addr_reg <= bus.in_addr;
    end
  end

  assign ded_addr = ded_addr_reg;
`else
  // No capture register in this build; the address bus is intentionally unused.
  logic unused_addr;
  assign unused_addr = ^bus.in_addr;
  assign ded_addr    = '0;
`endif

endmodule

// File: tb/tb_secded_err_logger.sv
module tb_secded_err_logger;
  localparam int CNT_W  = 4;
  localparam int ADDR_W = 12;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              log_clr = 1'b0;
  logic [CNT_W-1:0]  sec_cnt;
  logic [CNT_W-1:0]  ded_cnt;
  logic              ded_seen;
  logic [ADDR_W-1:0] ded_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  secded_err_logger_if #(.ADDR_W(ADDR_W)) bus ();

  secded_err_logger #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .log_clr  (log_clr),
    .sec_cnt  (sec_cnt),
    .ded_cnt  (ded_cnt),
    .ded_seen (ded_seen),
    .ded_addr (ded_addr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Held word plus plain event tallies; saturation applied only when compared.
  bit                m_valid = 1'b0;
  logic [15:0]       m_data  = '0;
  logic [1:0]        m_err   = '0;
  int                n_sec   = 0;
  int                n_ded   = 0;
  bit                m_seen  = 1'b0;
  logic [ADDR_W-1:0] m_addr  = '0;

  function automatic int sat(input int n);
    return (n > MAXC) ? MAXC : n;
  endfunction

  function automatic logic [31:0] exp_addr();
`ifdef SECDED_LOG_ADDR_EN
    return 32'(m_addr);
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    bit acc;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_valid = 0; m_data = '0; m_err = '0;
        n_sec = 0; n_ded = 0; m_seen = 0; m_addr = '0;
      end else begin
        acc = bus.in_valid && (!m_valid || bus.out_ready);
        if (acc) begin
          m_valid = 1;
          m_data  = bus.in_data;
          m_err   = bus.in_ded ? 2'b10 : (bus.in_sec ? 2'b01 : 2'b00);
        end else if (bus.out_ready) begin
          m_valid = 0;
        end
        if (log_clr) begin
          n_sec = 0; n_ded = 0; m_seen = 0; m_addr = '0;
        end else if (acc) begin
          if (bus.in_ded) begin
            n_ded++;
            if (!m_seen) begin
              m_seen = 1;
              m_addr = bus.in_addr;
            end
          end else if (bus.in_sec) begin
            n_sec++;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("in_ready",  32'(bus.in_ready),  32'(!m_valid || bus.out_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("out_data",  32'(bus.out_data),  32'(m_data));
      chk("out_err",   32'(bus.out_err),   32'(m_err));
      chk("sec_cnt",   32'(sec_cnt),       32'(sat(n_sec)));
      chk("ded_cnt",   32'(ded_cnt),       32'(sat(n_ded)));
      chk("ded_seen",  32'(ded_seen),      32'(m_seen));
      chk("ded_addr",  32'(ded_addr),      exp_addr());
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [15:0] d, input logic s, input logic e,
                      input logic [ADDR_W-1:0] a);
    bit acc;
    int waits = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sec = s; bus.in_ded = e; bus.in_addr = a;
    forever begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) break;
      waits++;
      if (waits > 40) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles required accept", waits);
        break;
      end
    end
    bus.in_valid = 1'b0;
    $display("xfer data=%h sec=%b ded=%b addr=%h clr=%b", d, s, e, a, log_clr);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_data"},  32'(bus.out_data),  32'd0);
    chk({tag, "_out_err"},   32'(bus.out_err),   32'd0);
    chk({tag, "_sec_cnt"},   32'(sec_cnt),       32'd0);
    chk({tag, "_ded_cnt"},   32'(ded_cnt),       32'd0);
    chk({tag, "_ded_seen"},  32'(ded_seen),      32'd0);
    chk({tag, "_ded_addr"},  32'(ded_addr),      32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sec = 1'b0; bus.in_ded = 1'b0;
    bus.in_addr = '0; bus.out_ready = 1'b1;

    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    @(posedge clk); #3 rst_n = 1'b1;
    idle(1);

    // Clean stream, one word per cycle.
    for (int i = 1; i <= 4; i++) send(16'(i), 1'b0, 1'b0, '0);
    chk("stream_last_data", 32'(bus.out_data), 32'h0004);
    chk("stream_err",       32'(bus.out_err),  32'd0);
    idle(1);
    chk("stream_drained",   32'(bus.out_valid), 32'd0);

    // SEC, then two DEDs; only the first DED address is kept.
    send(16'hA5A5, 1'b1, 1'b0, 12'h000);
    chk("sec_err", 32'(bus.out_err), 32'h1);
    send(16'h1234, 1'b0, 1'b1, 12'h010);
    send(16'hBEEF, 1'b0, 1'b1, 12'h020);
    idle(1);
    chk("log_sec_cnt",  32'(sec_cnt),  32'd1);
    chk("log_ded_cnt",  32'(ded_cnt),  32'd2);
    chk("log_ded_seen", 32'(ded_seen), 32'd1);
`ifdef SECDED_LOG_ADDR_EN
    chk("log_ded_addr", 32'(ded_addr), 32'h010);
`else
    chk("log_ded_addr", 32'(ded_addr), 32'h000);
`endif

    // Backpressure: 0x5555 held while 0x6666 waits.
    bus.out_ready = 1'b0;
    send(16'h5555, 1'b0, 1'b0, '0);
    bus.in_valid = 1'b1; bus.in_data = 16'h6666; bus.in_sec = 1'b0; bus.in_ded = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold",     32'(bus.out_data), 32'h5555);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    $display("xfer data=6666 sec=0 ded=0 addr=000 clr=0 (after stall)");
    chk("bp_release_data",  32'(bus.out_data),  32'h6666);
    chk("bp_release_valid", 32'(bus.out_valid), 32'd1);
    idle(1);
    chk("bp_no_dup", 32'(bus.out_valid), 32'd0);

    // Saturation with CNT_W=4.
    for (int i = 0; i < 20; i++) send(16'(16'h0100 + i), 1'b1, 1'b0, '0);
    idle(1);
    chk("sat_sec_cnt", 32'(sec_cnt), 32'd15);

    // Clear coincident with a DED: the DED is not logged.
    log_clr = 1'b1;
    send(16'hDEAD, 1'b0, 1'b1, 12'h0AA);
    log_clr = 1'b0;
    chk("clr_ded_cnt",  32'(ded_cnt),  32'd0);
    chk("clr_ded_seen", 32'(ded_seen), 32'd0);
    chk("clr_sec_cnt",  32'(sec_cnt),  32'd0);
    chk("clr_keeps_data", 32'(bus.out_data), 32'hDEAD);
    send(16'hC0DE, 1'b0, 1'b1, 12'h033);
    chk("post_clr_ded_cnt", 32'(ded_cnt), 32'd1);
`ifdef SECDED_LOG_ADDR_EN
    chk("post_clr_addr", 32'(ded_addr), 32'h033);
`else
    chk("post_clr_addr", 32'(ded_addr), 32'h000);
`endif

    // SEC and DED together count as DED only.
    send(16'h7777, 1'b1, 1'b1, 12'h044);
    chk("both_err",     32'(bus.out_err), 32'h2);
    chk("both_ded_cnt", 32'(ded_cnt),     32'd2);
    chk("both_sec_cnt", 32'(sec_cnt),     32'd0);

    // Reset mid-stream clears everything immediately.
    send(16'h1111, 1'b0, 1'b0, '0);
    bus.in_valid = 1'b1; bus.in_data = 16'h2222;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    bus.in_valid = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
